// File: rtl/renderer_scaled.sv
// renderer_scaled: copies the CHIP-8 display area of main RAM into the
// video framebuffer, replicating every pixel SCALE times in x and y.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start_signal          - one-cycle request to copy one frame
//   main_ram_read_address - main RAM read address (data returns next cycle)
//   main_ram_out          - main RAM read data
//   fb_write_address      - framebuffer write address
//   fb_write_enable       - framebuffer write strobe
//   fb_ram_in             - framebuffer write data
//   busy                  - high from first fetch through last write
//   finished_signal       - one-cycle pulse after the last write
module renderer_scaled #(
    parameter logic [11:0] SRC_BASE     = 12'h100,
    parameter int          SRC_W_BYTES  = 8,
    parameter int          SRC_H        = 32,
    parameter int          SCALE        = 2,
    parameter int          FB_ROW_BYTES = 16,
    parameter int          FB_BASE      = 0,
    parameter int          FB_AW        = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_signal,
    output logic [11:0]      main_ram_read_address,
    input  logic [7:0]       main_ram_out,
    output logic [FB_AW-1:0] fb_write_address,
    output logic             fb_write_enable,
    output logic [7:0]       fb_ram_in,
    output logic             busy,
    output logic             finished_signal
);

    localparam int COL_W = $clog2(SRC_W_BYTES + 1);
    localparam int ROW_W = $clog2(SRC_H + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        WRITE,
        DONE
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [1:0]       rep;
    logic [1:0]       half;
    logic [7:0]       pixel;

    logic [ROW_W-1:0] row_n;
    logic [COL_W-1:0] col_n;
    logic [1:0]       rep_n;
    logic             wrap;

    function automatic logic [11:0] src_addr(
        input logic [ROW_W-1:0] r,
        input logic [COL_W-1:0] c
    );
        return 12'(int'(SRC_BASE) + int'(r) * SRC_W_BYTES + int'(c));
    endfunction

    function automatic logic [FB_AW-1:0] dst_addr(
        input logic [ROW_W-1:0] r,
        input logic [1:0]       rp,
        input logic [COL_W-1:0] c,
        input logic [1:0]       h
    );
        return FB_AW'(FB_BASE
                      + (int'(r) * SCALE + int'(rp)) * FB_ROW_BYTES
                      + int'(c) * SCALE + int'(h));
    endfunction

    // At 2x each source bit becomes two adjacent framebuffer bits; the
    // left nibble feeds the first output byte, the right nibble the second.
    function automatic logic [7:0] expand(
        input logic [7:0] p,
        input logic [1:0] h
    );
        logic [3:0] n;
        if (SCALE == 1) begin
            return p;
        end
        n = h[0] ? p[3:0] : p[7:4];
        return {n[3], n[3], n[2], n[2], n[1], n[1], n[0], n[0]};
    endfunction

    // Counter advance: col innermost, then rep, then row.
    always_comb begin
        col_n = col;
        rep_n = rep;
        row_n = row;
        wrap  = 1'b0;
        if (col == COL_W'(SRC_W_BYTES - 1)) begin
            col_n = '0;
            if (rep == 2'(SCALE - 1)) begin
                rep_n = '0;
                if (row == ROW_W'(SRC_H - 1)) begin
                    row_n = '0;
                    wrap  = 1'b1;
                end else begin
                    row_n = row + ROW_W'(1);
                end
            end else begin
                rep_n = rep + 2'd1;
            end
        end else begin
            col_n = col + COL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            row                   <= '0;
            col                   <= '0;
            rep                   <= '0;
            half                  <= '0;
            pixel                 <= '0;
            main_ram_read_address <= '0;
            fb_write_address      <= '0;
            fb_write_enable       <= 1'b0;
            fb_ram_in             <= '0;
            busy                  <= 1'b0;
            finished_signal       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_signal) begin
                        row                   <= '0;
                        col                   <= '0;
                        rep                   <= '0;
                        half                  <= '0;
                        main_ram_read_address <= src_addr('0, '0);
                        busy                  <= 1'b1;
                        state                 <= FETCH;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    // Outputs are registered, so the first write's data
                    // is built straight from the RAM bus in this cycle.
                    pixel            <= main_ram_out;
                    half             <= '0;
                    fb_write_enable  <= 1'b1;
                    fb_write_address <= dst_addr(row, rep, col, 2'd0);
                    fb_ram_in        <= expand(main_ram_out, 2'd0);
                    state            <= WRITE;
                end
                WRITE: begin
                    if (half != 2'(SCALE - 1)) begin
                        half             <= half + 2'd1;
                        fb_write_address <= dst_addr(row, rep, col,
                                                     half + 2'd1);
                        fb_ram_in        <= expand(pixel, half + 2'd1);
                    end else begin
                        fb_write_enable <= 1'b0;
                        half            <= '0;
                        col             <= col_n;
                        rep             <= rep_n;
                        row             <= row_n;
                        if (wrap) begin
                            busy            <= 1'b0;
                            finished_signal <= 1'b1;
                            state           <= DONE;
                        end else begin
                            main_ram_read_address <= src_addr(row_n, col_n);
                            state                 <= FETCH;
                        end
                    end
                end
                DONE: begin
                    finished_signal <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_renderer_scaled.sv
// tb_renderer_scaled: random-stimulus bench for renderer_scaled, comparing
// framebuffer contents and frame timing against a pixel-level model.
module tb_renderer_scaled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    // ---------------- DUT A: defaults (SCALE=2) ----------------
    logic        a_reset, a_start, a_we, a_busy, a_fin, a_clr;
    logic [11:0] a_raddr;
    logic [7:0]  a_rdata, a_wdata;
    logic [9:0]  a_waddr;
    logic [7:0]  mem_a [4096];
    logic [7:0]  fb_a  [1024];

    renderer_scaled dut_a (
        .clk                   (clk),
        .reset                 (a_reset),
        .start_signal          (a_start),
        .main_ram_read_address (a_raddr),
        .main_ram_out          (a_rdata),
        .fb_write_address      (a_waddr),
        .fb_write_enable       (a_we),
        .fb_ram_in             (a_wdata),
        .busy                  (a_busy),
        .finished_signal       (a_fin)
    );

    always @(posedge clk) begin
        a_rdata <= mem_a[a_raddr];
        if (a_clr) begin
            for (int i = 0; i < 1024; i++) fb_a[i] <= 8'h00;
        end else if (a_we) begin
            fb_a[a_waddr] <= a_wdata;
        end
    end

    // ---------------- DUT B: SCALE=1, 8-byte rows ----------------
    logic        b_reset, b_start, b_we, b_busy, b_fin, b_clr;
    logic [11:0] b_raddr;
    logic [7:0]  b_rdata, b_wdata;
    logic [9:0]  b_waddr;
    logic [7:0]  mem_b [4096];
    logic [7:0]  fb_b  [1024];

    renderer_scaled #(.SCALE(1), .FB_ROW_BYTES(8)) dut_b (
        .clk                   (clk),
        .reset                 (b_reset),
        .start_signal          (b_start),
        .main_ram_read_address (b_raddr),
        .main_ram_out          (b_rdata),
        .fb_write_address      (b_waddr),
        .fb_write_enable       (b_we),
        .fb_ram_in             (b_wdata),
        .busy                  (b_busy),
        .finished_signal       (b_fin)
    );

    always @(posedge clk) begin
        b_rdata <= mem_b[b_raddr];
        if (b_clr) begin
            for (int i = 0; i < 1024; i++) fb_b[i] <= 8'h00;
        end else if (b_we) begin
            fb_b[b_waddr] <= b_wdata;
        end
    end

    // ---------------- activity monitors (negedge sampling) ----------------
    int   wcnt_a = 0, bcnt_a = 0, fcnt_a = 0;
    int   fin_cyc_a = 0, rise_cyc_a = 0, first_we_a = 0;
    logic busy_q_a = 1'b0, armed_a = 1'b0;

    always @(negedge clk) begin
        if (a_we) wcnt_a++;
        if (a_busy) bcnt_a++;
        if (a_fin) begin
            fcnt_a++;
            fin_cyc_a = cyc;
        end
        if (a_busy && !busy_q_a) begin
            rise_cyc_a = cyc;
            armed_a = 1'b1;
        end
        if (a_we && armed_a) begin
            first_we_a = cyc;
            armed_a = 1'b0;
        end
        busy_q_a = a_busy;
    end

    int   wcnt_b = 0, bcnt_b = 0, fcnt_b = 0;
    int   fin_cyc_b = 0, rise_cyc_b = 0, first_we_b = 0;
    logic busy_q_b = 1'b0, armed_b = 1'b0;

    always @(negedge clk) begin
        if (b_we) wcnt_b++;
        if (b_busy) bcnt_b++;
        if (b_fin) begin
            fcnt_b++;
            fin_cyc_b = cyc;
        end
        if (b_busy && !busy_q_b) begin
            rise_cyc_b = cyc;
            armed_b = 1'b1;
        end
        if (b_we && armed_b) begin
            first_we_b = cyc;
            armed_b = 1'b0;
        end
        busy_q_b = b_busy;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: scale every source pixel into an s x s block.
    logic [7:0] exp_fb [1024];

    task automatic model(input int which);
        int s, rowb, src, dst, xx, yy;
        logic [7:0] b;
        logic p;
        s    = (which == 0) ? 2 : 1;
        rowb = (which == 0) ? 16 : 8;
        for (int i = 0; i < 1024; i++) exp_fb[i] = 8'h00;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 64; x++) begin
                src = 'h100 + y * 8 + x / 8;
                b = (which == 0) ? mem_a[src] : mem_b[src];
                p = b[7 - x % 8];
                for (int dy = 0; dy < s; dy++) begin
                    for (int dx = 0; dx < s; dx++) begin
                        xx = x * s + dx;
                        yy = y * s + dy;
                        dst = yy * rowb + xx / 8;
                        exp_fb[dst][7 - xx % 8] = p;
                    end
                end
            end
        end
    endtask

    task automatic cmp_fb(input int which, input string tag);
        int bad;
        logic [7:0] v;
        model(which);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            v = (which == 0) ? fb_a[i] : fb_b[i];
            if (v !== exp_fb[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic clear_fb(input int which);
        @(negedge clk);
        if (which == 0) a_clr = 1'b1;
        else b_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        b_clr = 1'b0;
    endtask

    task automatic pulse_start(input int which, output int k);
        @(negedge clk);
        if (which == 0) a_start = 1'b1;
        else b_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        k = cyc;
    endtask

    function automatic int fcnt(input int which);
        return (which == 0) ? fcnt_a : fcnt_b;
    endfunction

    task automatic wait_fin(input int which, input int f0);
        int n;
        n = 0;
        while (fcnt(which) == f0 && n < 10000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 10000) check("fin_timeout", n, 0);
    endtask

    // One whole frame with timing checks; extra adds ignored start pulses.
    task automatic run_frame(input int which, input bit extra,
                             input string tag);
        int k, s, nf, nw, w0, b0, f0;
        s  = (which == 0) ? 2 : 1;
        nf = 32 * s * 8 * (2 + s);
        nw = 32 * s * 8 * s;
        clear_fb(which);
        w0 = (which == 0) ? wcnt_a : wcnt_b;
        b0 = (which == 0) ? bcnt_a : bcnt_b;
        f0 = fcnt(which);
        pulse_start(which, k);
        if (extra) begin
            while (cyc < k + 4) @(negedge clk);
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
            while (cyc < k + 999) @(negedge clk);
            a_start = 1'b1;
            @(negedge clk);
            a_start = 1'b0;
        end
        wait_fin(which, f0);
        repeat (6) @(posedge clk);
        if (which == 0) begin
            check({tag, "_fin_lat"}, fin_cyc_a - k + 1, nf + 1);
            check({tag, "_busy"}, bcnt_a - b0, nf);
            check({tag, "_writes"}, wcnt_a - w0, nw);
            check({tag, "_fetch_lat"}, rise_cyc_a - k + 1, 1);
            check({tag, "_wr_lat"}, first_we_a - k + 1, 3);
        end else begin
            check({tag, "_fin_lat"}, fin_cyc_b - k + 1, nf + 1);
            check({tag, "_busy"}, bcnt_b - b0, nf);
            check({tag, "_writes"}, wcnt_b - w0, nw);
            check({tag, "_fetch_lat"}, rise_cyc_b - k + 1, 1);
            check({tag, "_wr_lat"}, first_we_b - k + 1, 3);
        end
        check({tag, "_fin_cnt"}, fcnt(which) - f0, 1);
        cmp_fb(which, {tag, "_fb"});
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_we"}, int'(a_we), 0);
        check({tag, "_waddr"}, int'(a_waddr), 0);
        check({tag, "_wdata"}, int'(a_wdata), 0);
        check({tag, "_raddr"}, int'(a_raddr), 0);
        check({tag, "_busy"}, int'(a_busy), 0);
        check({tag, "_fin"}, int'(a_fin), 0);
    endtask

    initial begin
        int k, f0, w1, f1, n, bad;
        a_reset = 1'b1; a_start = 1'b0; a_clr = 1'b0;
        b_reset = 1'b1; b_start = 1'b0; b_clr = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_reset_a("rst");
        check("rst_b_busy", int'(b_busy), 0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // single top-left byte
        mem_a['h100] = 8'hA5;
        run_frame(0, 1'b0, "a5");
        check("a5_fb0", int'(fb_a[0]), 'hCC);
        check("a5_fb1", int'(fb_a[1]), 'h33);
        check("a5_fb16", int'(fb_a[16]), 'hCC);
        check("a5_fb17", int'(fb_a[17]), 'h33);

        // single bottom-right byte
        mem_a['h100] = 8'h00;
        mem_a['h1FF] = 8'h81;
        run_frame(0, 1'b0, "81");
        check("81_fb1006", int'(fb_a[1006]), 'hC0);
        check("81_fb1007", int'(fb_a[1007]), 'h03);
        check("81_fb1022", int'(fb_a[1022]), 'hC0);
        check("81_fb1023", int'(fb_a[1023]), 'h03);

        // random image, stray starts during the frame
        for (int i = 'h100; i < 'h200; i++) mem_a[i] = 8'($urandom);
        run_frame(0, 1'b1, "stray");

        // reset in the 300th busy cycle
        clear_fb(0);
        pulse_start(0, k);
        while (cyc < k + 299) @(negedge clk);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
        check_reset_a("midrst");
        @(posedge clk);
        w1 = wcnt_a;
        f1 = fcnt_a;
        repeat (40) @(posedge clk);
        check("midrst_nowr", wcnt_a - w1, 0);
        check("midrst_nofin", fcnt_a - f1, 0);
        check("midrst_idle", int'(a_busy), 0);
        for (int i = 'h100; i < 'h200; i++) mem_a[i] = 8'($urandom);
        run_frame(0, 1'b0, "post_rst");

        // start colliding with finished is dropped, next cycle accepted
        for (int i = 'h100; i < 'h200; i++) mem_a[i] = 8'($urandom);
        clear_fb(0);
        pulse_start(0, k);
        n = 0;
        while (!a_fin && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("coll_fin_seen", int'(a_fin), 1);
        a_start = 1'b1;
        @(negedge clk);
        check("coll_ignored", int'(a_busy), 0);
        @(negedge clk);
        a_start = 1'b0;
        k = cyc;
        check("coll_accept", int'(a_busy), 1);
        check("coll_raddr", int'(a_raddr), 'h100);
        f0 = fcnt_a;
        wait_fin(0, f0);
        repeat (6) @(posedge clk);
        check("coll_fin_lat", fin_cyc_a - k + 1, 2049);
        cmp_fb(0, "coll_fb");

        // SCALE=1 copy is an identity map of the display area
        for (int i = 0; i < 256; i++) mem_b['h100 + i] = 8'(i);
        run_frame(1, 1'b0, "s1");
        bad = 0;
        for (int i = 0; i < 256; i++) if (fb_b[i] !== 8'(i)) bad++;
        check("s1_ident", bad, 0);
        for (int i = 0; i < 256; i++) mem_b['h100 + i] = 8'($urandom);
        run_frame(1, 1'b0, "s1_rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
